mem_access_ctrl: RTL and testbench

- Sequences every load/store in the MEM stage of the pipelined RV32I core against a data cache with a valid/ready request channel and a response channel.
- Holds the pipeline with StallMem until the access completes.
- Delivers the extended load result to the MEM/WB pipeline register as ReadData, and drives byte enables for stores.
- Detects misaligned accesses and bus timeouts.

---
 rtl/mem_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 62 ++++++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data cache access controller.
package mem_pkg;

  // Sequencing states for one load/store.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // RV32I load/store funct3 encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access width after decoding funct3.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_t;

  // Any encoding that is not a byte or halfword access is handled as a word.
  function automatic acc_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

  // Natural alignment check on the low address bits.
  function automatic logic is_aligned(input acc_size_t sz, input logic [1:0] addr_lo);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      default: return (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational byte-lane steering: store byte enables and data
// shifting, plus selection and sign/zero extension of load data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_ext_o
);

  logic [4:0]  lane_shift;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign lane_shift = {addr_lo_i, 3'b000};

  // Store path: enables and data moved onto the addressed lanes, unused lanes zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    case (f3_size(funct3_i))
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {24'h00_0000, store_data_i[7:0]} << lane_shift;
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {16'h0000, store_data_i[15:0]} << lane_shift;
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

  // Load path: pick the addressed byte/half and extend it per funct3.
  always_comb begin
    byte_lane  = load_word_i[7:0];
    half_lane  = addr_lo_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    load_ext_o = load_word_i;
    case (addr_lo_i)
      2'd0:    byte_lane = load_word_i[7:0];
      2'd1:    byte_lane = load_word_i[15:8];
      2'd2:    byte_lane = load_word_i[23:16];
      default: byte_lane = load_word_i[31:24];
    endcase
    case (funct3_i)
      F3_B:    load_ext_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_ext_o = {24'h00_0000, byte_lane};
      F3_H:    load_ext_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_ext_o = {16'h0000, half_lane};
      default: load_ext_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for the pipelined RV32I core. Issues one
// valid/ready request per memory instruction, waits for the cache response,
// stalls the pipeline until the access completes and flags misaligned
// accesses and response timeouts.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  dreq_valid,
  input  logic                  dreq_ready,
  output logic                  dreq_we,
  output logic [DATA_WIDTH-1:0] dreq_addr,
  output logic [3:0]            dreq_be,
  output logic [DATA_WIDTH-1:0] dreq_wdata,
  input  logic                  dresp_valid,
  input  logic [DATA_WIDTH-1:0] dresp_data,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  StallMem,
  output logic                  MisalignM,
  output logic                  BusErrM
);

  // Counter value on the last WAIT cycle allowed before declaring a bus error.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mis_q, mis_d;
  logic                  berr_q, berr_d;

  logic                  op;
  logic                  aligned;
  logic [DATA_WIDTH-1:0] load_ext;

  assign op      = MemReadM | MemWriteM;
  assign aligned = is_aligned(f3_size(funct3M), ALUResultM[1:0]);

  mem_lane_align u_lane_align (
    .funct3_i     (funct3M),
    .addr_lo_i    (ALUResultM[1:0]),
    .store_data_i (WriteDataM),
    .load_word_i  (dresp_data),
    .be_o         (dreq_be),
    .wdata_o      (dreq_wdata),
    .load_ext_o   (load_ext)
  );

  // Request fields follow the M-stage inputs, which are frozen while stalled.
  assign dreq_valid = (state_q == REQ);
  assign dreq_we    = MemWriteM;
  assign dreq_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};

  // The instruction is released into MEM/WB only in DONE.
  assign StallMem  = op & (state_q != DONE);
  assign ReadData  = rdata_q;
  assign MisalignM = mis_q;
  assign BusErrM   = berr_q;

  // Next-state, timeout counter, result capture and event pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          if (aligned) begin
            state_d = REQ;
          end else begin
            // Misaligned: no request goes out, the instruction retires with 0.
            state_d = DONE;
            mis_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      REQ: begin
        if (dreq_ready) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (dresp_valid) begin
          state_d = DONE;
          rdata_d = MemWriteM ? '0 : load_ext;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          berr_d  = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a table of single accesses with
// immediate handshakes, then hand-written multi-cycle corner cases.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dreq_valid, dreq_ready, dreq_we;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_be;
  logic [31:0] dreq_wdata;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic [31:0] ReadData;
  logic        StallMem, MisalignM, BusErrM;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemReadM    (MemReadM),
    .MemWriteM   (MemWriteM),
    .funct3M     (funct3M),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .dreq_valid  (dreq_valid),
    .dreq_ready  (dreq_ready),
    .dreq_we     (dreq_we),
    .dreq_addr   (dreq_addr),
    .dreq_be     (dreq_be),
    .dreq_wdata  (dreq_wdata),
    .dresp_valid (dresp_valid),
    .dresp_data  (dresp_data),
    .ReadData    (ReadData),
    .StallMem    (StallMem),
    .MisalignM   (MisalignM),
    .BusErrM     (BusErrM)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    bit          done;
    int          stalls;
    int          vcnt;
    int          mis;
    int          berr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] rd;
    logic        mis_done;
    logic        berr_done;
    logic [31:0] post_rd;
    logic        post_stall;
  } res_t;

  // Runs one access from IDLE. Called just after a falling edge. The cache
  // raises ready once the request has been visible for ready_lat cycles and
  // responds resp_lat cycles into WAIT (never when resp_lat < 0).
  task automatic do_access(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] resp, input int ready_lat,
                           input int resp_lat, output res_t r);
    bit accepted;
    int wcnt;
    accepted = 1'b0;
    wcnt     = 0;
    r.done = 1'b0; r.stalls = 0; r.vcnt = 0; r.mis = 0; r.berr = 0;
    r.we = 1'b0; r.be = 4'h0; r.wdata = '0; r.addr = '0; r.rd = '0;
    r.mis_done = 1'b0; r.berr_done = 1'b0; r.post_rd = '0; r.post_stall = 1'b0;
    MemReadM   = rd_op;
    MemWriteM  = wr_op;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    dresp_data = resp;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (MisalignM) r.mis++;
      if (BusErrM) r.berr++;
      if (dreq_valid) begin
        r.vcnt++;
        r.we    = dreq_we;
        r.be    = dreq_be;
        r.wdata = dreq_wdata;
        r.addr  = dreq_addr;
      end
      if (!StallMem) begin
        r.done      = 1'b1;
        r.rd        = ReadData;
        r.mis_done  = MisalignM;
        r.berr_done = BusErrM;
        MemReadM    = 1'b0;
        MemWriteM   = 1'b0;
        dreq_ready  = 1'b0;
        dresp_valid = 1'b0;
        break;
      end
      r.stalls++;
      dresp_valid = 1'b0;
      if (accepted) begin
        if (wcnt == resp_lat) dresp_valid = 1'b1;
        wcnt++;
      end
      dreq_ready = dreq_valid && (r.vcnt > ready_lat);
      if (dreq_ready) accepted = 1'b1;
      @(negedge clk);
    end
    if (r.done) begin
      @(negedge clk);
      #1;
      if (MisalignM) r.mis++;
      if (BusErrM) r.berr++;
      r.post_rd    = ReadData;
      r.post_stall = StallMem;
    end
  endtask

  vec_t vecs [11];
  res_t r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed access table: immediate ready, response on first WAIT cycle.
    vecs[0]  = '{1'b0, F3_W,   32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 32'h0000_0100, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, F3_B,   32'h0000_0103, 32'h0, 32'h8011_2233, 4'b1000, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, F3_BU,  32'h0000_0103, 32'h0, 32'h8011_2233, 4'b1000, 32'h0000_0000, 32'h0000_0100, 32'h0000_0080};
    vecs[3]  = '{1'b0, F3_H,   32'h0000_0102, 32'h0, 32'h8011_2233, 4'b1100, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_8011};
    vecs[4]  = '{1'b0, F3_HU,  32'h0000_0100, 32'h0, 32'h8011_2233, 4'b0011, 32'h0000_0000, 32'h0000_0100, 32'h0000_2233};
    vecs[5]  = '{1'b0, F3_B,   32'h0000_0101, 32'h0, 32'h8011_2233, 4'b0010, 32'h0000_0000, 32'h0000_0100, 32'h0000_0022};
    vecs[6]  = '{1'b1, F3_B,   32'h0000_0101, 32'h1234_56AB, 32'hFFFF_FFFF, 4'b0010, 32'h0000_AB00, 32'h0000_0100, 32'h0000_0000};
    vecs[7]  = '{1'b1, F3_H,   32'h0000_0102, 32'hCAFE_BEEF, 32'hFFFF_FFFF, 4'b1100, 32'hBEEF_0000, 32'h0000_0100, 32'h0000_0000};
    vecs[8]  = '{1'b1, F3_W,   32'h0000_0204, 32'h1122_3344, 32'hFFFF_FFFF, 4'b1111, 32'h1122_3344, 32'h0000_0204, 32'h0000_0000};
    vecs[9]  = '{1'b0, F3_HU,  32'h0000_0102, 32'h0, 32'hFFFE_0001, 4'b1100, 32'h0000_0000, 32'h0000_0100, 32'h0000_FFFE};
    vecs[10] = '{1'b0, 3'b011, 32'h0000_0108, 32'h0, 32'h89AB_CDEF, 4'b1111, 32'h0000_0000, 32'h0000_0108, 32'h89AB_CDEF};

    rst = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = F3_W;
    ALUResultM = '0; WriteDataM = '0;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ReadData",   ReadData,   32'h0);
    check("reset StallMem",   32'(StallMem),   32'h0);
    check("reset dreq_valid", 32'(dreq_valid), 32'h0);
    check("reset MisalignM",  32'(MisalignM),  32'h0);
    check("reset BusErrM",    32'(BusErrM),    32'h0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      do_access(~vecs[i].is_st, vecs[i].is_st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].resp, 0, 0, r);
      check($sformatf("vec%0d done", i),     32'(r.done),   32'h1);
      check($sformatf("vec%0d stalls", i),   32'(r.stalls), 32'd3);
      check($sformatf("vec%0d valid", i),    32'(r.vcnt),   32'd1);
      check($sformatf("vec%0d we", i),       32'(r.we),     32'(vecs[i].is_st));
      check($sformatf("vec%0d be", i),       32'(r.be),     32'(vecs[i].exp_be));
      check($sformatf("vec%0d wdata", i),    r.wdata,       vecs[i].exp_wdata);
      check($sformatf("vec%0d addr", i),     r.addr,        vecs[i].exp_addr);
      check($sformatf("vec%0d ReadData", i), r.rd,          vecs[i].exp_rd);
      check($sformatf("vec%0d hold", i),     r.post_rd,     vecs[i].exp_rd);
      check($sformatf("vec%0d pulses", i),   32'(r.mis + r.berr), 32'd0);
    end

    // Misaligned word load: no request, one-cycle MisalignM, result forced to 0.
    do_access(1'b1, 1'b0, F3_W, 32'h0000_0102, 32'h0, 32'h5555_5555, 0, 0, r);
    check("misalign lw done",     32'(r.done),     32'h1);
    check("misalign lw stalls",   32'(r.stalls),   32'd1);
    check("misalign lw valid",    32'(r.vcnt),     32'd0);
    check("misalign lw in DONE",  32'(r.mis_done), 32'h1);
    check("misalign lw pulses",   32'(r.mis),      32'd1);
    check("misalign lw ReadData", r.rd,            32'h0);

    // Misaligned halfword store: nothing written.
    do_access(1'b0, 1'b1, F3_H, 32'h0000_0103, 32'hFFFF_FFFF, 32'h0, 0, 0, r);
    check("misalign sh valid",  32'(r.vcnt), 32'd0);
    check("misalign sh pulses", 32'(r.mis),  32'd1);

    // Load a nonzero value so the timeout result is observable.
    do_access(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 32'h1357_9BDF, 0, 0, r);
    check("preload ReadData", r.rd, 32'h1357_9BDF);

    // Timeout: accepted but never answered; four WAIT cycles then BusErrM.
    do_access(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 32'h0, 0, -1, r);
    check("timeout done",     32'(r.done),      32'h1);
    check("timeout stalls",   32'(r.stalls),    32'd6);
    check("timeout in DONE",  32'(r.berr_done), 32'h1);
    check("timeout pulses",   32'(r.berr),      32'd1);
    check("timeout misalign", 32'(r.mis),       32'd0);
    check("timeout ReadData", r.rd,             32'h0);

    // Store with ready held low for two cycles.
    do_access(1'b0, 1'b1, F3_B, 32'h0000_0102, 32'h0000_00AB, 32'h0, 2, 0, r);
    check("sb wait valid",    32'(r.vcnt),   32'd3);
    check("sb wait stalls",   32'(r.stalls), 32'd5);
    check("sb wait be",       32'(r.be),     32'b0100);
    check("sb wait wdata",    r.wdata,       32'h00AB_0000);
    check("sb wait addr",     r.addr,        32'h0000_0100);
    check("sb wait ReadData", r.rd,          32'h0);

    // Reset during WAIT, then a late response that must be ignored.
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = F3_W;
    ALUResultM = 32'h0000_0100; dresp_data = 32'h1234_5678;
    @(negedge clk); #1;
    check("rst seq REQ valid", 32'(dreq_valid), 32'h1);
    dreq_ready = 1'b1;
    @(negedge clk); #1;
    dreq_ready = 1'b0;
    check("rst seq WAIT stall", 32'(StallMem), 32'h1);
    rst = 1'b1;
    MemReadM = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    check("rst seq valid", 32'(dreq_valid), 32'h0);
    check("rst seq stall", 32'(StallMem),   32'h0);
    dresp_valid = 1'b1;
    @(negedge clk); #1;
    dresp_valid = 1'b0;
    check("rst seq ReadData", ReadData,          32'h0);
    check("rst seq late valid", 32'(dreq_valid), 32'h0);
    check("rst seq late stall", 32'(StallMem),   32'h0);
    check("rst seq late buserr", 32'(BusErrM),   32'h0);
    @(negedge clk);

    // Normal operation after the mid-access reset.
    do_access(1'b1, 1'b0, F3_W, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 0, r);
    check("recover stalls",   32'(r.stalls), 32'd3);
    check("recover ReadData", r.rd,          32'h0BAD_F00D);
    check("recover no stall", 32'(r.post_stall), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
